msi_snoop_cluster: RTL and testbench
====================================

# msi_snoop_cluster

Parametrised MSI snooping-coherence controller for `N_CORES` private caches of `N_LINES` lines each, sharing one serialised snoop bus. It replaces the fixed two-machine emitter/receiver pair. It adds:
- round-robin arbitration among cores;
- per-core, per-line state arrays;
- explicit bus, writeback and abort phases.

Cores issue RM/RH/WM/WH operations. The block updates the requester's state and the state of every snooping core, then acknowledges the requester.

## Interface
- `N_CORES`, default 4: number of caches, minimum 2.
- `N_LINES`, default 4: lines per cache, power of two, minimum 2.
- `CW = $clog2(N_CORES)`, `LW = $clog2(N_LINES)`: derived, not overridable.

Clock is one domain. Reset is asynchronous, active-low.
- `i_Clock` in 1: the single clock.
- `i_Reset_n` in 1: asynchronous reset, active low.
- `i_Req` in N_CORES: level request per core; held until `o_Ack`.
- `i_Op` in 2*N_CORES: per-core operation, packed core 0 in [1:0]. Encoding RM=0, RH=1, WM=2, WH=3.
- `i_Line` in LW*N_CORES: per-core line index, packed.
- `i_Poke_En` in 1: test write of one state entry, honoured only in IDLE.
- `i_Poke_Core`, `i_Poke_Line`, `i_Poke_State` in CW/LW/2: target and value for the poke.
- `i_Dbg_Core`, `i_Dbg_Line` in CW/LW: readout select.
- `o_Dbg_State` out 2: combinational state of the selected entry.
- `o_Ack` out N_CORES: one-cycle pulse on the granted core.
- `o_Busy` out 1: high in every state except IDLE.
- `o_Bus_Valid` out 1: high only in BUS.
- `o_Bus_Msg` out 2: NONE=0, READ_MISS=1, WRITE_MISS=2, INVALIDATE=3.
- `o_Bus_Src` out CW: granted core.
- `o_Bus_Line` out LW: line of the current transaction.
- `o_Writeback` out 1: high only in WB.
- `o_Wb_Src` out CW: core writing back.
- `o_Abort` out 1: pulse in DONE when a snooper held the line MODIFIED.

## Operation
State encoding is INVALID=0, SHARED=1, MODIFIED=2; value 3 is never produced.

FSM states: IDLE, DECODE, BUS, WB, DONE.
- **IDLE**: apply the poke if `i_Poke_En`; the poke takes priority over a grant in the same cycle. Otherwise, if any `i_Req` is high, grant the highest-priority requester and latch its op and line, then go to DECODE.
- **DECODE**: compute the requester's next state and bus message.
  - RH or WH on an INVALID line is treated as RM or WM respectively.
  - I+RM: next S, READ_MISS.
  - I+WM: next M, WRITE_MISS.
  - S+RH: stay S, NONE.
  - S+RM: stay S, READ_MISS.
  - S+WH: next M, INVALIDATE.
  - S+WM: next M, WRITE_MISS.
  - M+RH or M+WH: stay M, NONE.
  - M+RM: next S, READ_MISS, self writeback.
  - M+WM: stay M, WRITE_MISS, self writeback.
  - Go to DONE if the message is NONE, otherwise to BUS.
- **BUS**: broadcast the message. At the end of the cycle every core other than the requester updates its entry for `o_Bus_Line`:
  - READ_MISS: M goes to S (abort plus writeback); S stays S.
  - WRITE_MISS: S or M goes to I (M also aborts plus writes back).
  - INVALIDATE: S or M goes to I, with no writeback.
  - INVALID entries are unchanged.
  - Go to WB if a self or snooper writeback is pending, otherwise to DONE.
- **WB**: source selection, then go to DONE.
  - `o_Wb_Src` is the snooper if one aborted, otherwise the requester.
  - If both a snooper and a self writeback are pending, the snooper wins and the self writeback is dropped. This case is unreachable without a poke.
  - If more than one snooper is MODIFIED (poke only), the lowest index is reported.
- **DONE**: write the requester's next state, pulse `o_Ack[grant]` and `o_Abort` (if set), then go to IDLE.

Arbitration:
- Round-robin; after a grant to g, priority order is g+1, g+2, … modulo N_CORES.
- The priority pointer resets to 0, so core 0 has highest priority first.

## Timing
- Requests are sampled on the rising edge in IDLE.
- Cycle offsets from the sampling edge k (cycle k+1 is DECODE):

  | Transaction | Cycles after k | o_Ack high in cycle |
  |---|---|---|
  | Hit (no bus) | 2 | k+2 |
  | Miss, no writeback | 3 | k+3 |
  | Miss with writeback | 4 | k+4 |

- `i_Req`, `i_Op` and `i_Line` of the granted core must stay stable until `o_Ack`. Requests are ignored during DONE, so a requester may deassert in the ack cycle. At most one transaction is granted per IDLE visit.
- Other cores' requests are held pending, never lost.
- Reset is asynchronous, at any point including mid-transaction:
  - all state entries go to INVALID;
  - FSM goes to IDLE and the pointer to 0;
  - all outputs go to 0, `o_Dbg_State` reads 0;
  - no `o_Ack` is issued for an aborted transaction.
- `o_Bus_Msg`, `o_Bus_Src`, `o_Bus_Line` are 0 outside BUS; `o_Wb_Src` is 0 outside WB.

## Structure
- Package `msi_pkg`: state, op and message enums; `emitter_next` and `receiver_next` pure functions returning next state plus message or writeback flags.
- Sub-module `msi_rr_arbiter`, parameter N: inputs req and advance; outputs one-hot grant and index; contains the pointer register.
- State arrays use flat 2-bit registers indexed by [core][line].

## Test plan
Configuration for all scenarios: N_CORES=4, N_LINES=4.
1. Reset, then release: every `o_Dbg_State` reads 0 and every output is 0. Assert reset mid-BUS: no ack, all entries return to 0.
2. Core0 RM on line 2 sampled at edge k → `o_Bus_Msg`=1 in cycle k+2, `o_Ack`=0001 in k+3, core0.L2=S. Then core1 RM on line 2 → core0.L2 and core1.L2 both S.
3. Core1 WH on line 2 (S) → INVALIDATE, no WB, core1.L2=M, core0.L2=I.
4. Core0 RM on line 2 while core1 holds M → `o_Writeback` with `o_Wb_Src`=1, `o_Abort` pulses, both S, ack at k+4.
5. Poke core3.L1=M, then core3 WM on line 1 → WRITE_MISS, self WB with `o_Wb_Src`=3, no abort, core3.L1 stays M.
6. After a grant to core0, hold RH requests from cores 0, 2 and 3 simultaneously → acks in order 2, 3, 0, each with 2-cycle latency and no bus activity.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared MSI coherence types and the pure next-state functions used by the
// requester (emitter) and snooper (receiver) sides of the cluster.
package msi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_M = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_RM = 2'd0,
    OP_RH = 2'd1,
    OP_WM = 2'd2,
    OP_WH = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'd0,
    MSG_READ_MISS  = 2'd1,
    MSG_WRITE_MISS = 2'd2,
    MSG_INVALIDATE = 2'd3
  } msg_e;

  typedef enum logic [2:0] {
    FSM_IDLE   = 3'd0,
    FSM_DECODE = 3'd1,
    FSM_BUS    = 3'd2,
    FSM_WB     = 3'd3,
    FSM_DONE   = 3'd4
  } fsm_e;

  typedef struct packed {
    state_e nxt;
    msg_e   msg;
    logic   wb;
  } emit_t;

  typedef struct packed {
    logic [1:0] nxt;
    logic       wb;
  } rcv_t;

  // Requester transition; hits on an invalid line degrade to the matching miss.
  function automatic emit_t emitter_next(input logic [1:0] cur, input op_e op);
    emit_t r;
    r = '{nxt: ST_I, msg: MSG_NONE, wb: 1'b0};
    case (cur)
      2'd1: begin
        case (op)
          OP_RH:   r = '{nxt: ST_S, msg: MSG_NONE,       wb: 1'b0};
          OP_RM:   r = '{nxt: ST_S, msg: MSG_READ_MISS,  wb: 1'b0};
          OP_WH:   r = '{nxt: ST_M, msg: MSG_INVALIDATE, wb: 1'b0};
          default: r = '{nxt: ST_M, msg: MSG_WRITE_MISS, wb: 1'b0};
        endcase
      end
      2'd2: begin
        case (op)
          OP_RM:   r = '{nxt: ST_S, msg: MSG_READ_MISS,  wb: 1'b1};
          OP_WM:   r = '{nxt: ST_M, msg: MSG_WRITE_MISS, wb: 1'b1};
          default: r = '{nxt: ST_M, msg: MSG_NONE,       wb: 1'b0};
        endcase
      end
      default: begin
        if (op == OP_RM || op == OP_RH) r = '{nxt: ST_S, msg: MSG_READ_MISS, wb: 1'b0};
        else                            r = '{nxt: ST_M, msg: MSG_WRITE_MISS, wb: 1'b0};
      end
    endcase
    return r;
  endfunction

  // Snooper transition; wb flags a modified copy that must be written back.
  function automatic rcv_t receiver_next(input logic [1:0] cur, input msg_e msg);
    rcv_t r;
    r = '{nxt: cur, wb: 1'b0};
    case (msg)
      MSG_READ_MISS:  if (cur == 2'd2) r = '{nxt: 2'd1, wb: 1'b1};
      MSG_WRITE_MISS: begin
        if (cur == 2'd1) r = '{nxt: 2'd0, wb: 1'b0};
        if (cur == 2'd2) r = '{nxt: 2'd0, wb: 1'b1};
      end
      MSG_INVALIDATE: if (cur == 2'd1 || cur == 2'd2) r = '{nxt: 2'd0, wb: 1'b0};
      default: r = '{nxt: cur, wb: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/msi_rr_arbiter.sv
// Round-robin arbiter; pointer moves to one past the granted index on advance.
module msi_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] cand;
  logic         found;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = W'((int'(ptr) + i) % int'(N));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
    end
  end

endmodule

// File: rtl/msi_snoop_cluster.sv
// MSI snooping controller: serialises core requests onto one snoop bus and
// keeps per-core, per-line coherence state.
module msi_snoop_cluster
  import msi_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned N_LINES = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [N_CORES-1:0]            i_Req,
  input  logic [2*N_CORES-1:0]          i_Op,
  input  logic [$clog2(N_LINES)*N_CORES-1:0] i_Line,
  input  logic                          i_Poke_En,
  input  logic [$clog2(N_CORES)-1:0]    i_Poke_Core,
  input  logic [$clog2(N_LINES)-1:0]    i_Poke_Line,
  input  logic [1:0]                    i_Poke_State,
  input  logic [$clog2(N_CORES)-1:0]    i_Dbg_Core,
  input  logic [$clog2(N_LINES)-1:0]    i_Dbg_Line,
  output logic [1:0]                    o_Dbg_State,
  output logic [N_CORES-1:0]            o_Ack,
  output logic                          o_Busy,
  output logic                          o_Bus_Valid,
  output logic [1:0]                    o_Bus_Msg,
  output logic [$clog2(N_CORES)-1:0]    o_Bus_Src,
  output logic [$clog2(N_LINES)-1:0]    o_Bus_Line,
  output logic                          o_Writeback,
  output logic [$clog2(N_CORES)-1:0]    o_Wb_Src,
  output logic                          o_Abort
);

  localparam int unsigned CW = $clog2(N_CORES);
  localparam int unsigned LW = $clog2(N_LINES);

  logic [N_CORES-1:0][N_LINES-1:0][1:0] st;

  fsm_e          fsm;
  logic [CW-1:0] gnt_q;
  op_e           op_q;
  logic [LW-1:0] line_q;
  logic [1:0]    req_next_q;
  msg_e          msg_q;
  logic          self_wb_q;
  logic          abort_q;

  logic [N_CORES-1:0] arb_grant;
  logic [CW-1:0]      arb_idx;
  logic               arb_advance;
  op_e                req_op_c;
  logic [LW-1:0]      req_line_c;
  emit_t              emit_c;
  logic [N_CORES-1:0] ack_vec;
  logic [N_CORES-1:0][1:0] snoop_next;
  logic               snoop_any;
  logic [CW-1:0]      snoop_idx;
  rcv_t               rcv;

  assign o_Dbg_State = st[i_Dbg_Core][i_Dbg_Line];
  assign arb_advance = (fsm == FSM_IDLE) && !i_Poke_En;

  msi_rr_arbiter #(.N(N_CORES)) u_arb (
    .clk     (i_Clock),
    .rst_n   (i_Reset_n),
    .req     (i_Req),
    .advance (arb_advance),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  // Op and line of the core the arbiter is offering this cycle.
  always_comb begin
    req_op_c   = OP_RM;
    req_line_c = '0;
    for (int c = 0; c < int'(N_CORES); c++) begin
      if (CW'(c) == arb_idx) begin
        req_op_c   = op_e'(i_Op[2*c +: 2]);
        req_line_c = i_Line[LW*c +: LW];
      end
    end
  end

  always_comb begin
    emit_c         = emitter_next(st[gnt_q][line_q], op_q);
    ack_vec        = '0;
    ack_vec[gnt_q] = 1'b1;
  end

  // Snooper updates for the bus line; lowest-index modified snooper reports the writeback.
  always_comb begin
    snoop_any = 1'b0;
    snoop_idx = '0;
    rcv       = '{nxt: 2'd0, wb: 1'b0};
    for (int c = 0; c < int'(N_CORES); c++) begin
      snoop_next[c] = st[c][line_q];
      rcv = receiver_next(st[c][line_q], msg_q);
      if (CW'(c) != gnt_q) begin
        snoop_next[c] = rcv.nxt;
        if (rcv.wb && !snoop_any) begin
          snoop_any = 1'b1;
          snoop_idx = CW'(c);
        end
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      st          <= '0;
      fsm         <= FSM_IDLE;
      gnt_q       <= '0;
      op_q        <= OP_RM;
      line_q      <= '0;
      req_next_q  <= 2'd0;
      msg_q       <= MSG_NONE;
      self_wb_q   <= 1'b0;
      abort_q     <= 1'b0;
      o_Ack       <= '0;
      o_Busy      <= 1'b0;
      o_Bus_Valid <= 1'b0;
      o_Bus_Msg   <= 2'd0;
      o_Bus_Src   <= '0;
      o_Bus_Line  <= '0;
      o_Writeback <= 1'b0;
      o_Wb_Src    <= '0;
      o_Abort     <= 1'b0;
    end else begin
      o_Ack       <= '0;
      o_Abort     <= 1'b0;
      o_Bus_Valid <= 1'b0;
      o_Bus_Msg   <= 2'd0;
      o_Bus_Src   <= '0;
      o_Bus_Line  <= '0;
      o_Writeback <= 1'b0;
      o_Wb_Src    <= '0;
      case (fsm)
        FSM_IDLE: begin
          if (i_Poke_En) begin
            st[i_Poke_Core][i_Poke_Line] <= i_Poke_State;
          end else if (|arb_grant) begin
            gnt_q  <= arb_idx;
            op_q   <= req_op_c;
            line_q <= req_line_c;
            fsm    <= FSM_DECODE;
            o_Busy <= 1'b1;
          end
        end
        FSM_DECODE: begin
          req_next_q <= emit_c.nxt;
          msg_q      <= emit_c.msg;
          self_wb_q  <= emit_c.wb;
          abort_q    <= 1'b0;
          if (emit_c.msg == MSG_NONE) begin
            fsm   <= FSM_DONE;
            o_Ack <= ack_vec;
          end else begin
            fsm         <= FSM_BUS;
            o_Bus_Valid <= 1'b1;
            o_Bus_Msg   <= emit_c.msg;
            o_Bus_Src   <= gnt_q;
            o_Bus_Line  <= line_q;
          end
        end
        FSM_BUS: begin
          for (int c = 0; c < int'(N_CORES); c++) st[c][line_q] <= snoop_next[c];
          abort_q <= snoop_any;
          if (snoop_any || self_wb_q) begin
            fsm         <= FSM_WB;
            o_Writeback <= 1'b1;
            o_Wb_Src    <= snoop_any ? snoop_idx : gnt_q;
          end else begin
            fsm   <= FSM_DONE;
            o_Ack <= ack_vec;
          end
        end
        FSM_WB: begin
          fsm     <= FSM_DONE;
          o_Ack   <= ack_vec;
          o_Abort <= abort_q;
        end
        FSM_DONE: begin
          st[gnt_q][line_q] <= req_next_q;
          fsm    <= FSM_IDLE;
          o_Busy <= 1'b0;
        end
        default: begin
          fsm    <= FSM_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msi_snoop_cluster.sv
// Directed bench for msi_snoop_cluster (4 cores x 4 lines): reset, miss/hit
// sequences, snooper writeback, self writeback and round-robin ordering.
module tb_msi_snoop_cluster;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] op;
  logic [7:0] line;
  logic       poke_en;
  logic [1:0] poke_core, poke_line, poke_state;
  logic [1:0] dbg_core, dbg_line, dbg_state;
  logic [3:0] ack;
  logic       busy, bus_valid, writeback, abort;
  logic [1:0] bus_msg, bus_src, bus_line, wb_src;

  int n_vec = 0;
  int n_err = 0;

  msi_snoop_cluster #(.N_CORES(4), .N_LINES(4)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Req        (req),
    .i_Op         (op),
    .i_Line       (line),
    .i_Poke_En    (poke_en),
    .i_Poke_Core  (poke_core),
    .i_Poke_Line  (poke_line),
    .i_Poke_State (poke_state),
    .i_Dbg_Core   (dbg_core),
    .i_Dbg_Line   (dbg_line),
    .o_Dbg_State  (dbg_state),
    .o_Ack        (ack),
    .o_Busy       (busy),
    .o_Bus_Valid  (bus_valid),
    .o_Bus_Msg    (bus_msg),
    .o_Bus_Src    (bus_src),
    .o_Bus_Line   (bus_line),
    .o_Writeback  (writeback),
    .o_Wb_Src     (wb_src),
    .o_Abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input int c, input int l, input logic [1:0] exp, input string tag);
    dbg_core = 2'(c);
    dbg_line = 2'(l);
    #1;
    chk(tag, {6'd0, dbg_state}, {6'd0, exp});
  endtask

  // Packed view of all registered outputs for "everything is zero" checks.
  function automatic logic [7:0] outs_or();
    return {4'd0, |ack, busy | bus_valid | writeback | abort,
            |{bus_msg, bus_src, bus_line}, |wb_src};
  endfunction

  task automatic set_req(input int c, input logic [1:0] o, input logic [1:0] l);
    req[c]          = 1'b1;
    op[2*c +: 2]    = o;
    line[2*c +: 2]  = l;
  endtask

  task automatic poke(input logic [1:0] c, input logic [1:0] l, input logic [1:0] s);
    poke_en    = 1'b1;
    poke_core  = c;
    poke_line  = l;
    poke_state = s;
    step();
    poke_en    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; op = '0; line = '0;
    poke_en = 1'b0; poke_core = '0; poke_line = '0; poke_state = '0;
    dbg_core = '0; dbg_line = '0;
    #1;
    chk("reset_outs", outs_or(), 8'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1. Post-reset state and outputs
    chk("idle_outs", outs_or(), 8'd0);
    for (int c = 0; c < 4; c++)
      for (int l = 0; l < 4; l++)
        chk_st(c, l, 2'd0, "reset_state");

    // 1b. Reset in the middle of a BUS phase
    step();
    poke(2'd1, 2'd3, 2'd1);
    chk_st(1, 3, 2'd1, "poke_c1l3");
    step();
    set_req(2, 2'd2, 2'd0);
    step();
    chk("midrst_decode_busy", {7'd0, busy}, 8'd1);
    step();
    chk("midrst_bus_valid", {7'd0, bus_valid}, 8'd1);
    chk("midrst_bus_msg", {6'd0, bus_msg}, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_outs", outs_or(), 8'd0);
    req = '0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_ack", {4'd0, ack}, 8'd0);
    end
    chk_st(1, 3, 2'd0, "midrst_c1l3");
    chk_st(2, 0, 2'd0, "midrst_c2l0");

    // 2. Core0 RM line2: read miss, ack at k+3
    step();
    set_req(0, 2'd0, 2'd2);
    step();
    chk("s2_decode_bus", {7'd0, bus_valid}, 8'd0);
    step();
    chk("s2_bus_msg", {6'd0, bus_msg}, 8'd1);
    chk("s2_bus_src", {6'd0, bus_src}, 8'd0);
    chk("s2_bus_line", {6'd0, bus_line}, 8'd2);
    step();
    chk("s2_ack", {4'd0, ack}, 8'h1);
    req = '0;
    step();
    chk("s2_ack_clear", {4'd0, ack}, 8'h0);
    chk_st(0, 2, 2'd1, "s2_c0l2");

    // 2b. Core1 RM line2: both shared
    step();
    set_req(1, 2'd0, 2'd2);
    step(); step();
    chk("s2b_bus_msg", {6'd0, bus_msg}, 8'd1);
    chk("s2b_bus_src", {6'd0, bus_src}, 8'd1);
    step();
    chk("s2b_ack", {4'd0, ack}, 8'h2);
    req = '0;
    step();
    chk_st(0, 2, 2'd1, "s2b_c0l2");
    chk_st(1, 2, 2'd1, "s2b_c1l2");

    // 3. Core1 WH line2 from S: invalidate, no writeback
    step();
    set_req(1, 2'd3, 2'd2);
    step(); step();
    chk("s3_bus_msg", {6'd0, bus_msg}, 8'd3);
    step();
    chk("s3_no_wb", {7'd0, writeback}, 8'd0);
    chk("s3_ack", {4'd0, ack}, 8'h2);
    req = '0;
    step();
    chk_st(1, 2, 2'd2, "s3_c1l2");
    chk_st(0, 2, 2'd0, "s3_c0l2");

    // 4. Core0 RM line2 with core1 modified: snooper writeback and abort
    step();
    set_req(0, 2'd0, 2'd2);
    step(); step();
    chk("s4_bus_msg", {6'd0, bus_msg}, 8'd1);
    step();
    chk("s4_wb", {7'd0, writeback}, 8'd1);
    chk("s4_wb_src", {6'd0, wb_src}, 8'd1);
    chk("s4_no_early_ack", {4'd0, ack}, 8'h0);
    step();
    chk("s4_ack", {4'd0, ack}, 8'h1);
    chk("s4_abort", {7'd0, abort}, 8'd1);
    chk("s4_wb_src_clear", {6'd0, wb_src}, 8'd0);
    req = '0;
    step();
    chk("s4_abort_clear", {7'd0, abort}, 8'd0);
    chk_st(0, 2, 2'd1, "s4_c0l2");
    chk_st(1, 2, 2'd1, "s4_c1l2");

    // 5. Core3 WM on a poked-modified line: self writeback, no abort
    step();
    poke(2'd3, 2'd1, 2'd2);
    chk_st(3, 1, 2'd2, "s5_poke");
    step();
    set_req(3, 2'd2, 2'd1);
    step(); step();
    chk("s5_bus_msg", {6'd0, bus_msg}, 8'd2);
    chk("s5_bus_src", {6'd0, bus_src}, 8'd3);
    chk("s5_bus_line", {6'd0, bus_line}, 8'd1);
    step();
    chk("s5_wb", {7'd0, writeback}, 8'd1);
    chk("s5_wb_src", {6'd0, wb_src}, 8'd3);
    step();
    chk("s5_ack", {4'd0, ack}, 8'h8);
    chk("s5_no_abort", {7'd0, abort}, 8'd0);
    req = '0;
    step();
    chk_st(3, 1, 2'd2, "s5_c3l1");

    // 6. Round-robin among hits after a grant to core0
    step();
    poke(2'd2, 2'd0, 2'd1);
    step();
    set_req(0, 2'd1, 2'd2);
    step();
    chk("s6_pre_nobus", {7'd0, bus_valid}, 8'd0);
    step();
    chk("s6_pre_ack", {4'd0, ack}, 8'h1);
    req = '0;
    step();
    set_req(0, 2'd1, 2'd2);
    set_req(2, 2'd1, 2'd0);
    set_req(3, 2'd1, 2'd1);
    step();
    chk("s6_a_nobus", {7'd0, bus_valid}, 8'd0);
    step();
    chk("s6_ack_core2", {4'd0, ack}, 8'h4);
    req[2] = 1'b0;
    step();
    chk("s6_idle1", {7'd0, busy}, 8'd0);
    step();
    chk("s6_b_nobus", {7'd0, bus_valid}, 8'd0);
    step();
    chk("s6_ack_core3", {4'd0, ack}, 8'h8);
    req[3] = 1'b0;
    step(); step();
    chk("s6_c_nobus", {7'd0, bus_valid}, 8'd0);
    step();
    chk("s6_ack_core0", {4'd0, ack}, 8'h1);
    req = '0;
    step();
    chk_st(0, 2, 2'd1, "s6_c0l2");
    chk_st(2, 0, 2'd1, "s6_c2l0");
    chk_st(3, 1, 2'd2, "s6_c3l1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
